// File: rtl/biriscv_mul_issue_arbiter.sv
// Arbitrates the shared pipelined multiplier between the two issue slots and
// tracks in-flight multiplies for writeback steering and RAW interlock.
module biriscv_mul_issue_arbiter #(
    parameter int MULT_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        issue0_valid_i,
    input  logic [31:0] issue0_opcode_i,
    input  logic [4:0]  issue0_rd_idx_i,
    input  logic [31:0] issue0_ra_operand_i,
    input  logic [31:0] issue0_rb_operand_i,

    input  logic        issue1_valid_i,
    input  logic [31:0] issue1_opcode_i,
    input  logic [4:0]  issue1_rd_idx_i,
    input  logic [31:0] issue1_ra_operand_i,
    input  logic [31:0] issue1_rb_operand_i,

    input  logic        hold_i,
    input  logic        flush_i,

    output logic        issue0_accept_o,
    output logic        issue1_accept_o,

    output logic        mul_valid_o,
    output logic [31:0] mul_opcode_o,
    output logic [4:0]  mul_rd_idx_o,
    output logic [31:0] mul_ra_operand_o,
    output logic [31:0] mul_rb_operand_o,

    output logic        wb_valid_o,
    output logic        wb_slot_o,
    output logic [4:0]  wb_rd_idx_o,

    output logic [31:0] busy_rd_mask_o
);

    localparam logic [31:0] INST_MUL      = 32'h02000033;
    localparam logic [31:0] INST_MUL_MASK = 32'hfe00707f;
    localparam logic [31:0] INST_MULH     = 32'h02001033;
    localparam logic [31:0] INST_MULH_MASK = 32'hfe00707f;
    localparam logic [31:0] INST_MULHSU   = 32'h02002033;
    localparam logic [31:0] INST_MULHSU_MASK = 32'hfe00707f;
    localparam logic [31:0] INST_MULHU    = 32'h02003033;
    localparam logic [31:0] INST_MULHU_MASK = 32'hfe00707f;

    function automatic logic is_mul(input logic [31:0] op);
        is_mul = ((op & INST_MUL_MASK)    == INST_MUL)    ||
                 ((op & INST_MULH_MASK)   == INST_MULH)   ||
                 ((op & INST_MULHSU_MASK) == INST_MULHSU) ||
                 ((op & INST_MULHU_MASK)  == INST_MULHU);
    endfunction

    logic req0;
    logic req1;
    logic grant_ok;

    assign req0     = issue0_valid_i & is_mul(issue0_opcode_i);
    assign req1     = issue1_valid_i & is_mul(issue1_opcode_i);
    // rst gates the grant so every combinational output reads zero during reset
    assign grant_ok = ~hold_i & ~flush_i & ~rst;

    assign issue0_accept_o = req0 & grant_ok;
    assign issue1_accept_o = req1 & ~req0 & grant_ok;

    always_comb begin
        mul_valid_o      = 1'b0;
        mul_opcode_o     = 32'd0;
        mul_rd_idx_o     = 5'd0;
        mul_ra_operand_o = 32'd0;
        mul_rb_operand_o = 32'd0;
        if (issue0_accept_o) begin
            mul_valid_o      = 1'b1;
            mul_opcode_o     = issue0_opcode_i;
            mul_rd_idx_o     = issue0_rd_idx_i;
            mul_ra_operand_o = issue0_ra_operand_i;
            mul_rb_operand_o = issue0_rb_operand_i;
        end else if (issue1_accept_o) begin
            mul_valid_o      = 1'b1;
            mul_opcode_o     = issue1_opcode_i;
            mul_rd_idx_o     = issue1_rd_idx_i;
            mul_ra_operand_o = issue1_ra_operand_i;
            mul_rb_operand_o = issue1_rb_operand_i;
        end
    end

    // Entry 0 is e1; entry MULT_STAGES-1 lines up with the multiplier result
    logic [MULT_STAGES-1:0]      stage_valid;
    logic [MULT_STAGES-1:0]      stage_slot;
    logic [MULT_STAGES-1:0][4:0] stage_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid <= '0;
            stage_slot  <= '0;
            stage_rd    <= '0;
        end else if (flush_i) begin
            stage_valid <= '0;
        end else if (!hold_i) begin
            stage_valid <= {stage_valid[MULT_STAGES-2:0], mul_valid_o};
            stage_slot  <= {stage_slot[MULT_STAGES-2:0], issue1_accept_o};
            stage_rd    <= {stage_rd[MULT_STAGES-2:0], mul_rd_idx_o};
        end
    end

    assign wb_valid_o  = stage_valid[MULT_STAGES-1];
    assign wb_slot_o   = stage_slot[MULT_STAGES-1];
    assign wb_rd_idx_o = stage_rd[MULT_STAGES-1];

    always_comb begin
        busy_rd_mask_o = 32'd0;
        for (int i = 0; i < MULT_STAGES; i++) begin
            if (stage_valid[i] && (stage_rd[i] != 5'd0))
                busy_rd_mask_o[stage_rd[i]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_biriscv_mul_issue_arbiter.sv
// Randomised scoreboard bench for the multiplier issue arbiter, exercising
// both supported multiplier depths side by side from the same stimulus.
module tb_biriscv_mul_issue_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i0_v, i1_v, hold, flush;
    logic [31:0] i0_op, i0_ra, i0_rb, i1_op, i1_ra, i1_rb;
    logic [4:0]  i0_rd, i1_rd;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    typedef struct {
        bit       slot;
        bit [4:0] rd;
        int       due;
    } ent_t;

    // Architectural meaning: R-type, funct7=0000001, funct3 in MUL..MULHU
    function automatic bit model_is_mul(input logic [31:0] op);
        return (op[6:0] == 7'h33) && (op[31:25] == 7'h01) && (op[14:12] < 3'd4);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_st
        localparam int ST = 2 + g;

        logic        acc0, acc1, mv, wbv, wbs;
        logic [31:0] mop, mra, mrb, mask;
        logic [4:0]  mrd, wbrd;
        int          checks = 0;
        int          errors = 0;
        ent_t        q[$];
        int          adv = 0;

        biriscv_mul_issue_arbiter #(.MULT_STAGES(ST)) dut (
            .clk(clk), .rst(rst),
            .issue0_valid_i(i0_v), .issue0_opcode_i(i0_op), .issue0_rd_idx_i(i0_rd),
            .issue0_ra_operand_i(i0_ra), .issue0_rb_operand_i(i0_rb),
            .issue1_valid_i(i1_v), .issue1_opcode_i(i1_op), .issue1_rd_idx_i(i1_rd),
            .issue1_ra_operand_i(i1_ra), .issue1_rb_operand_i(i1_rb),
            .hold_i(hold), .flush_i(flush),
            .issue0_accept_o(acc0), .issue1_accept_o(acc1),
            .mul_valid_o(mv), .mul_opcode_o(mop), .mul_rd_idx_o(mrd),
            .mul_ra_operand_o(mra), .mul_rb_operand_o(mrb),
            .wb_valid_o(wbv), .wb_slot_o(wbs), .wb_rd_idx_o(wbrd),
            .busy_rd_mask_o(mask)
        );

        task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
            checks++;
            n_checks++;
            if (act !== exp) begin
                errors++;
                n_errors++;
                $display("FAIL stages=%0d %s at %0t: got %h expected %h", ST, nm, $time, act, exp);
            end
        endtask

        // Monitor: samples mid-cycle, compares against the queue model, then advances it
        always @(negedge clk) begin
            bit          r0, r1, ea0, ea1, ewb;
            logic [31:0] emask, eop, era, erb;
            logic [4:0]  erd;
            if (rst) q.delete();
            r0  = i0_v && model_is_mul(i0_op);
            r1  = i1_v && model_is_mul(i1_op);
            ea0 = !rst && !hold && !flush && r0;
            ea1 = !rst && !hold && !flush && r1 && !r0;
            eop = 0; erd = 0; era = 0; erb = 0;
            if (ea0) begin eop = i0_op; erd = i0_rd; era = i0_ra; erb = i0_rb; end
            else if (ea1) begin eop = i1_op; erd = i1_rd; era = i1_ra; erb = i1_rb; end
            chk("issue0_accept", 32'(acc0), 32'(ea0));
            chk("issue1_accept", 32'(acc1), 32'(ea1));
            chk("mul_valid", 32'(mv), 32'(ea0 | ea1));
            chk("mul_opcode", mop, eop);
            chk("mul_rd_idx", 32'(mrd), 32'(erd));
            chk("mul_ra", mra, era);
            chk("mul_rb", mrb, erb);

            ewb   = (q.size() > 0) && (q[0].due == adv);
            emask = 0;
            foreach (q[i]) if (q[i].rd != 0) emask = emask | (32'd1 << q[i].rd);
            chk("wb_valid", 32'(wbv), 32'(ewb));
            if (ewb) begin
                chk("wb_slot", 32'(wbs), 32'(q[0].slot));
                chk("wb_rd_idx", 32'(wbrd), 32'(q[0].rd));
            end
            if (rst) begin
                chk("wb_slot_rst", 32'(wbs), 0);
                chk("wb_rd_rst", 32'(wbrd), 0);
            end
            chk("busy_rd_mask", mask, emask);
            if (q.size() > 0 && q[0].due < adv)
                chk("wb_overdue", 0, 1);

            if (!rst) begin
                if (flush) q.delete();
                else if (!hold) begin
                    if (ewb) void'(q.pop_front());
                    if (ea0 || ea1) q.push_back('{slot: ea1, rd: erd, due: adv + ST});
                    adv++;
                end
            end
        end
    end

    function automatic logic [31:0] mkop(input int f3, input logic [4:0] rd);
        logic [2:0] f = f3[2:0];
        return {7'h01, 5'd2, 5'd1, f, rd, 7'h33};
    endfunction

    task automatic step(input logic v0, input logic [31:0] op0, input logic [4:0] rd0,
                        input logic v1, input logic [31:0] op1, input logic [4:0] rd1,
                        input logic h, input logic f);
        i0_v = v0; i0_op = op0; i0_rd = rd0; i0_ra = $urandom; i0_rb = $urandom;
        i1_v = v1; i1_op = op1; i1_rd = rd1; i1_ra = $urandom; i1_rb = $urandom;
        hold = h; flush = f;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] rand_op(input logic [4:0] rd);
        int k = $urandom_range(0, 6);
        if (k < 4) return mkop(k, rd);
        if (k == 4) return mkop($urandom_range(4, 7), rd);
        if (k == 5) return {7'h00, 10'h041, 3'd0, rd, 7'h33};
        return $urandom;
    endfunction

    initial begin
        rst = 1'b1;
        i0_v = 0; i0_op = 0; i0_rd = 0; i0_ra = 0; i0_rb = 0;
        i1_v = 0; i1_op = 0; i1_rd = 0; i1_ra = 0; i1_rb = 0;
        hold = 0; flush = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // slot 0 MUL rd5, ra=3 rb=7
        i0_v = 1; i0_op = mkop(0, 5); i0_rd = 5; i0_ra = 3; i0_rb = 7;
        @(posedge clk); #1;
        idle(4);
        // both request: MULH rd4 on slot 0, MUL rd6 on slot 1 which retries
        step(1, mkop(1, 4), 4, 1, mkop(0, 6), 6, 0, 0);
        step(0, 0, 0, 1, mkop(0, 6), 6, 0, 0);
        idle(4);
        // ADD on slot 0, MULHU on slot 1
        step(1, {7'h00, 10'h041, 3'd0, 5'd3, 7'h33}, 3, 1, mkop(3, 9), 9, 0, 0);
        idle(4);
        // grant, then two held cycles
        step(1, mkop(0, 7), 7, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        idle(5);
        // grants in T and T+1 with flush in T+1
        step(1, mkop(0, 10), 10, 0, 0, 0, 0, 0);
        step(1, mkop(0, 11), 11, 0, 0, 0, 0, 1);
        idle(5);
        // flush together with hold
        step(1, mkop(2, 12), 12, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        idle(5);
        // rd=0 never shows in the mask
        step(1, mkop(0, 0), 0, 0, 0, 0, 0, 0);
        idle(5);
        // reset mid-flight
        step(1, mkop(0, 13), 13, 1, mkop(1, 14), 14, 0, 0);
        step(0, 0, 0, 1, mkop(1, 14), 14, 0, 0);
        rst = 1'b1;
        step(1, mkop(0, 15), 15, 1, mkop(0, 16), 16, 0, 0);
        step(1, mkop(0, 15), 15, 0, 0, 0, 0, 0);
        rst = 1'b0;
        idle(4);

        for (int c = 0; c < 4000; c++) begin
            logic [4:0] r0 = 5'($urandom_range(0, 31));
            logic [4:0] r1 = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) r1 = r0;
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            else rst = 1'b0;
            step($urandom_range(0, 3) != 0, rand_op(r0), r0,
                 $urandom_range(0, 3) != 0, rand_op(r1), r1,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0);
        end
        rst = 1'b0;
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/biriscv_mul_issue_arbiter.md
# biriscv_mul_issue_arbiter

Shares the single pipelined multiplier between the two issue slots of the dual-issue pipeline. It grants at most one multiply-class instruction per cycle and steers that slot's operands onto the multiplier's opcode interface. It tracks every in-flight multiply so that the writeback slot and rd index line up with the multiplier's result, and it publishes an rd scoreboard that the issue logic uses for RAW interlock.

## Interface
- MULT_STAGES, 2, multiplier latency in cycles (2 or 3); must equal the multiplier's configured stages
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- issue0_valid_i  in  1  slot 0 (older instruction) has an instruction
- issue0_opcode_i  in  32  slot 0 instruction word
- issue0_rd_idx_i  in  5  slot 0 destination register
- issue0_ra_operand_i / issue0_rb_operand_i  in  32 each  slot 0 source operands
- issue1_valid_i, issue1_opcode_i, issue1_rd_idx_i, issue1_ra_operand_i, issue1_rb_operand_i  in  1/32/5/32/32  slot 1 (younger instruction), same meaning as slot 0
- hold_i  in  1  pipeline stall; same signal as the multiplier's hold_i
- flush_i  in  1  kill all in-flight multiplies (branch mispredict or exception)
- issue0_accept_o / issue1_accept_o  out  1 each  slot granted the multiplier this cycle
- mul_valid_o  out  1  to multiplier opcode_valid_i
- mul_opcode_o  out  32  to multiplier opcode_opcode_i
- mul_rd_idx_o  out  5  to multiplier opcode_rd_idx_i
- mul_ra_operand_o / mul_rb_operand_o  out  32 each  to multiplier operand inputs
- wb_valid_o  out  1  multiplier writeback_value_o is valid this cycle
- wb_slot_o  out  1  issue slot that owns the result (0 or 1)
- wb_rd_idx_o  out  5  destination register of the result
- busy_rd_mask_o  out  32  bit n is set while any valid in-flight multiply targets xn; bit 0 is always 0

## Operation
- Multiply-class decode: an opcode is multiply-class when it matches MUL, MULH, MULHSU or MULHU under the standard INST_*_MASK definitions. req0 = issue0_valid_i and slot 0 is multiply-class. req1 is defined the same way for slot 1.
- Grant logic is combinational:
  - issue0_accept_o = req0 and not hold_i and not flush_i.
  - issue1_accept_o = req1 and not req0 and not hold_i and not flush_i.
  - Slot 0 has fixed priority because it is program-order older. A losing slot 1 retries on the next cycle, and the issue logic stalls it.
- Operand mux: the granted slot drives mul_opcode_o, mul_rd_idx_o, mul_ra_operand_o and mul_rb_operand_o. With no grant these outputs are all zero and mul_valid_o=0. An opcode of zero makes the multiplier load zeros.
- Tracking pipeline: one entry per multiplier stage. Each entry holds {valid, slot, rd}.
  - Stage e1 loads the grant on the edge where the multiplier captures its operands.
  - e1 moves to e2 on the next edge, and e2 moves to e3 when MULT_STAGES=3.
  - The final stage (e2 or e3) drives wb_valid_o, wb_slot_o and wb_rd_idx_o.
- Scoreboard: busy_rd_mask_o is the OR of one-hot(rd) over all valid entries in e1..final. Entries with rd=0 contribute nothing. The mask is combinational from the registered entries.
- Precedence at an edge, highest first:
  1. rst.
  2. flush_i: clear every valid; no new entry is loaded.
  3. hold_i: all entries keep their value.
  4. Normal advance: e1 takes the grant, or valid=0 if there is no grant.
- The multiplier's own datapath is not killed by flush_i. Its stale result still appears, but wb_valid_o=0 suppresses it.

## Timing
- Reset: all tracking valid=0, slot=0, rd=0. While rst is high, every output is 0: accept, mul_*, wb_*, busy_rd_mask_o.
- Grant-to-writeback latency is exactly MULT_STAGES unheld cycles. For a grant in cycle T with no hold, wb_valid_o is asserted in cycle T+MULT_STAGES, the same cycle the multiplier presents the result.
- Each cycle of hold_i while an entry is in flight delays its writeback by one cycle. While held, wb_valid_o and the wb fields are stable.
- Throughput is one multiply per cycle. Back-to-back grants produce back-to-back wb_valid_o.
- busy_rd_mask_o sets a bit in cycle T+1 after a grant in cycle T. The bit clears in the cycle after that entry's wb_valid_o cycle, unless a younger in-flight entry has the same rd.
- A flush_i asserted in cycle T drops all valids from T+1 onward, and there is no grant in cycle T.

## Test plan
- Slot 0 MUL, rd=5, ra=3, rb=7, MULT_STAGES=2 -> issue0_accept_o=1 in cycle T; busy bit 5 set in T+1 and T+2; in T+2, wb_valid_o=1, wb_slot_o=0, wb_rd_idx_o=5 and the multiplier returns 21; bit 5 clear in T+3.
- Both slots request in the same cycle (slot 0 MULH rd=4, slot 1 MUL rd=6) -> slot 0 granted in T, slot 1 granted in T+1; writebacks occur in T+2 (slot 0, rd 4) and T+3 (slot 1, rd 6).
- Slot 1 MULHU alone, plus non-multiply ADD on slot 0 -> issue1_accept_o=1 and issue0_accept_o=0; mul_opcode_o equals slot 1's opcode.
- Grant in T, hold_i high for cycles T+1 and T+2 -> wb_valid_o asserted in T+4; result value and rd are unchanged from the unheld case.
- Grants in T and T+1, flush_i in T+1 -> no grant in T+1, no wb_valid_o in any later cycle, busy_rd_mask_o=0 from T+2; flush_i together with hold_i also clears.
- MULT_STAGES=3 with a MUL to rd=0 -> writeback in T+3 with wb_rd_idx_o=0, and busy_rd_mask_o stays 0 throughout; assert rst mid-flight -> all outputs 0 immediately.
